// File: rtl/layer1_mac_sequencer_if.sv
// Stream and multiplier signals of the Layer1 MAC sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface layer1_mac_sequencer_if #(
  parameter int ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_weight;
  logic [7:0]       in_pixel;
  logic [15:0]      mul_a;
  logic [7:0]       mul_b;
  logic [23:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  in_valid, in_weight, in_pixel, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_data
  );

  modport master (
    output in_valid, in_weight, in_pixel, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_data
  );
endinterface

// File: rtl/layer1_mac_sequencer.sv
// Runs one convolution window through a shared 16x8 multiplier, accumulating
// weight*pixel products onto a bias, then returns a ReLU'd, saturated result.
module layer1_mac_sequencer #(
  parameter int TAP_W = 8,
  parameter int ACC_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_idle,
  output logic             ap_done,
  input  logic [TAP_W-1:0] tap_count,
  input  logic [ACC_W-1:0] bias,
  input  logic             relu_en,
  layer1_mac_sequencer_if.slave bus
);

  // Two guard bits: 255 * 2^23 plus a full-range bias cannot wrap.
  localparam int AW = ACC_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] taps_q, taps_d;
  logic             relu_q, relu_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [15:0]      mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;
  logic [23:0]      p_q, p_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             done_q, done_d;

  logic             can_accept;
  logic             accept;
  logic [AW-1:0]    relu_val;
  logic [ACC_W-1:0] sat_val;

  assign can_accept = (state_q == S_RUN) && (cnt_q < taps_q);
  assign accept     = can_accept && bus.in_valid;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    p_d     = p_q;
    v1_d    = 1'b0;
    v2_d    = v1_q;
    done_d  = 1'b0;

    if (v1_q) p_d = bus.mul_p;
    if (v2_q) acc_d = acc_q + {{(AW-24){p_q[23]}}, p_q};

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          taps_d  = tap_count;
          relu_d  = relu_en;
          acc_d   = {{2{bias[ACC_W-1]}}, bias};
          cnt_d   = '0;
          state_d = (tap_count != '0) ? S_RUN : S_OUT;
        end
      end
      S_RUN: begin
        if (accept) begin
          mul_a_d = bus.in_weight;
          mul_b_d = bus.in_pixel;
          v1_d    = 1'b1;
          cnt_d   = cnt_q + TAP_W'(1);
          if (cnt_d == taps_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // With no product left in stage 1, stage 3 finishes this cycle.
        if (!v1_q) state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    relu_val = (relu_q && acc_q[AW-1]) ? '0 : acc_q;
    sat_val  = relu_val[ACC_W-1:0];
    // The top three bits must agree for the value to fit in ACC_W signed bits.
    if (!((&relu_val[AW-1:ACC_W-1]) || ~(|relu_val[AW-1:ACC_W-1]))) begin
      sat_val = relu_val[AW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      taps_q  <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      p_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      relu_q  <= relu_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      p_q     <= p_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      done_q  <= done_d;
    end
  end

  assign ap_idle       = (state_q == S_IDLE);
  assign ap_done       = done_q;
  assign bus.in_ready  = can_accept;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = (state_q == S_OUT) ? sat_val : '0;

endmodule

// File: tb/tb_layer1_mac_sequencer.sv
// Directed bench for layer1_mac_sequencer with a behavioural 16x8 multiplier
// and hand-computed window results.
module tb_layer1_mac_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [7:0]  tap_count;
  logic [31:0] bias;
  logic        relu_en;

  int checks   = 0;
  int failures = 0;

  logic [15:0] wq[4];
  logic [7:0]  pq[4];

  layer1_mac_sequencer_if bus ();

  layer1_mac_sequencer dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .tap_count(tap_count),
    .bias     (bias),
    .relu_en  (relu_en),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // Signed weight times zero-extended pixel; the product always fits 24 signed bits.
  assign bus.mul_p = $signed({{8{bus.mul_a[15]}}, bus.mul_a}) * $signed({16'd0, bus.mul_b});

  // Called at a falling edge with the sequencer idle; returns at the falling edge of cycle 1.
  task automatic start_window(input logic [7:0] n, input logic [31:0] b, input logic r);
    tap_count = n;
    bias      = b;
    relu_en   = r;
    ap_start  = 1'b1;
    @(negedge ap_clk);
    ap_start  = 1'b0;
  endtask

  // Presents wq/pq pairs; with gaps set, in_valid alternates 1,0,1,0...
  task automatic drive_pairs(input int n, input bit gaps, inout int cyc);
    int  idx = 0;
    int  t   = 0;
    bit  took;
    while (idx < n && t < 100) begin
      bus.in_valid  = gaps ? (t % 2 == 0) : 1'b1;
      bus.in_weight = wq[idx];
      bus.in_pixel  = pq[idx];
      took = bus.in_valid && bus.in_ready;
      @(negedge ap_clk);
      cyc++;
      t++;
      if (took) idx++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(inout int cyc);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 30) begin
      @(negedge ap_clk);
      cyc++;
      k++;
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; ap_start = 1'b0; tap_count = '0; bias = '0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_weight = '0; bus.in_pixel = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", ap_idle); end
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", ap_done); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.mul_a !== 16'd0 || bus.mul_b !== 8'd0) begin failures++; $display("FAIL rst_mul got=%h/%h exp=0/0", bus.mul_a, bus.mul_b); end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL post_rst_idle got=%b exp=1", ap_idle); end
  endtask

  task automatic test_basic_mac;
    int cyc = 1;
    wq[0] = 16'hFFFE; pq[0] = 8'd5;
    wq[1] = 16'd3;    pq[1] = 8'd7;
    wq[2] = 16'd100;  pq[2] = 8'd255;
    start_window(8'd3, 32'd10, 1'b0);
    drive_pairs(3, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (cyc != 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", cyc); end
    checks++; if (bus.out_data !== 32'd25521) begin failures++; $display("FAIL basic_data got=%0d exp=25521", $signed(bus.out_data)); end
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", ap_done); end
    @(negedge ap_clk);
    checks++; if (ap_done !== 1'b1 || ap_idle !== 1'b1) begin failures++; $display("FAIL basic_done got=%b/%b exp=1/1", ap_done, ap_idle); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_clear got=%b exp=0", bus.out_valid); end
    @(negedge ap_clk);
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", ap_done); end
  endtask

  task automatic test_relu;
    int cyc = 1;
    wq[0] = 16'hFFFC; pq[0] = 8'd200;
    start_window(8'd1, 32'hFFFFFC18, 1'b1);
    drive_pairs(1, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0) begin failures++; $display("FAIL relu_on got=%h exp=00000000", bus.out_data); end
    @(negedge ap_clk);
    cyc = 1;
    start_window(8'd1, 32'hFFFFFC18, 1'b0);
    drive_pairs(1, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFF8F8) begin failures++; $display("FAIL relu_off got=%h exp=fffff8f8", bus.out_data); end
    @(negedge ap_clk);
  endtask

  task automatic test_zero_taps;
    int  cyc = 1;
    bit  saw_ready = 1'b0;
    @(negedge ap_clk);
    tap_count = 8'd0; bias = 32'hFFFFFFF9; relu_en = 1'b0; ap_start = 1'b1;
    if (bus.in_ready) saw_ready = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    if (bus.in_ready) saw_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zero_latency got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hFFFFFFF9) begin failures++; $display("FAIL zero_data got=%h exp=fffffff9", bus.out_data); end
    wait_out(cyc);
    @(negedge ap_clk);
    if (bus.in_ready) saw_ready = 1'b1;
    checks++; if (saw_ready) begin failures++; $display("FAIL zero_in_ready got=1 exp=0"); end
  endtask

  task automatic test_backpressure;
    int          cyc = 1;
    int          pulses = 0;
    logic [31:0] held;
    wq[0] = 16'd1;    pq[0] = 8'd1;
    wq[1] = 16'd2;    pq[1] = 8'd2;
    wq[2] = 16'd3;    pq[2] = 8'd3;
    wq[3] = 16'hFFFF; pq[3] = 8'd10;
    bus.out_ready = 1'b0;
    start_window(8'd4, 32'd100, 1'b0);
    drive_pairs(4, 1'b1, cyc);
    wait_out(cyc);
    held = bus.out_data;
    checks++; if (held !== 32'd104) begin failures++; $display("FAIL bp_data got=%0d exp=104", $signed(held)); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd104 || bus.in_ready !== 1'b0 || ap_done !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%b d=%0d r=%b done=%b exp v=1 d=104 r=0 done=0",
                 i, bus.out_valid, $signed(bus.out_data), bus.in_ready, ap_done);
      end
      @(negedge ap_clk);
    end
    bus.out_ready = 1'b1;
    @(negedge ap_clk);
    checks++; if (ap_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", ap_done); end
    for (int i = 0; i < 4; i++) begin
      if (ap_done === 1'b1) pulses++;
      @(negedge ap_clk);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_saturation;
    int cyc = 1;
    wq[0] = 16'd32767; pq[0] = 8'd255;
    start_window(8'd1, 32'h7FFFFF00, 1'b0);
    drive_pairs(1, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fffffff", bus.out_data); end
    @(negedge ap_clk);
    cyc = 1;
    wq[0] = 16'h8000; pq[0] = 8'd255;
    start_window(8'd1, 32'h80000010, 1'b0);
    drive_pairs(1, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h80000000) begin failures++; $display("FAIL sat_neg got=%h exp=80000000", bus.out_data); end
    @(negedge ap_clk);
  endtask

  task automatic test_reset_mid_window;
    int  cyc = 1;
    bit  bad = 1'b0;
    start_window(8'd4, 32'd50, 1'b0);
    bus.in_valid = 1'b1; bus.in_weight = 16'd9; bus.in_pixel = 8'd9;
    repeat (2) @(negedge ap_clk);
    bus.in_valid = 1'b0;
    ap_rst = 1'b1;
    @(negedge ap_clk);
    checks++; if (ap_idle !== 1'b1 || bus.out_valid !== 1'b0 || ap_done !== 1'b0) begin failures++; $display("FAIL midrst_state got idle=%b v=%b done=%b exp 1/0/0", ap_idle, bus.out_valid, ap_done); end
    checks++; if (bus.mul_a !== 16'd0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_clear got mul_a=%h r=%b exp 0/0", bus.mul_a, bus.in_ready); end
    ap_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      if (ap_done !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL midrst_quiet got=activity exp=none"); end
    wq[0] = 16'd2; pq[0] = 8'd3;
    start_window(8'd1, 32'd0, 1'b0);
    drive_pairs(1, 1'b0, cyc);
    wait_out(cyc);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd6) begin failures++; $display("FAIL midrst_fresh got=%0d exp=6", $signed(bus.out_data)); end
    @(negedge ap_clk);
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_relu();
    test_zero_taps();
    test_backpressure();
    test_saturation();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
